// File: rtl/bcd_counter_multi_if.sv
// Control and result bundle between a BCD counter and the logic that drives it.
interface bcd_counter_multi_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  load;
  logic                  up;
  logic [4*DIGITS-1:0]   in;
  logic [4*DIGITS-1:0]   q;
  logic                  tick;
  logic                  carry;

  modport master (output en, load, up, in, input q, tick, carry);
  modport slave  (input en, load, up, in, output q, tick, carry);
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter stepped by an internal clock-enable prescaler.
// One registered stage: q, tick and carry change on the edge that samples the step.
module bcd_counter_multi #(
  parameter int                  DIGITS = 2,
  parameter int                  DIV    = 50000000,
  parameter logic [4*DIGITS-1:0] TOP    = 'h99
) (
  input  logic                clk,
  input  logic                clr,
  bcd_counter_multi_if.slave  bus
);
  localparam int             W        = 4 * DIGITS;
  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PSC_LAST = PW'(DIV - 1);

  logic [PW-1:0] psc_q, psc_d;
  logic [W-1:0]  q_q, q_d;
  logic          tick_q, carry_q;
  logic          step;
  logic          wrap;
  logic [W-1:0]  ld_val, inc_val, dec_val;
  logic          inc_c, dec_b;
  logic [3:0]    nib;

  always_comb begin
    step  = bus.en && (psc_q == PSC_LAST);
    psc_d = psc_q;
    if (bus.en) begin
      psc_d = step ? '0 : psc_q + 1'b1;
    end
  end

  // Per-digit sanitise of the load value and single-cycle ripple inc/dec.
  always_comb begin
    ld_val  = '0;
    inc_val = q_q;
    dec_val = q_q;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    nib     = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      nib                = bus.in[4*d +: 4];
      ld_val[4*d +: 4]   = (nib > 4'd9) ? 4'd0 : nib;
      if (inc_c) begin
        if (q_q[4*d +: 4] == 4'd9) begin
          inc_val[4*d +: 4] = 4'd0;
        end else begin
          inc_val[4*d +: 4] = q_q[4*d +: 4] + 4'd1;
          inc_c             = 1'b0;
        end
      end
      if (dec_b) begin
        if (q_q[4*d +: 4] == 4'd0) begin
          dec_val[4*d +: 4] = 4'd9;
        end else begin
          dec_val[4*d +: 4] = q_q[4*d +: 4] - 4'd1;
          dec_b             = 1'b0;
        end
      end
    end
  end

  // Packed BCD orders the same as binary, so a plain compare detects q above TOP.
  always_comb begin
    q_d  = q_q;
    wrap = 1'b0;
    if (bus.up) begin
      if (q_q >= TOP) begin
        q_d  = '0;
        wrap = 1'b1;
      end else begin
        q_d = inc_val;
      end
    end else begin
      if (q_q == '0) begin
        q_d  = TOP;
        wrap = 1'b1;
      end else begin
        q_d = dec_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      psc_q   <= '0;
      q_q     <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      psc_q   <= '0;
      q_q     <= ld_val;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      tick_q  <= step;
      carry_q <= step && wrap;
      if (step) begin
        q_q <= q_d;
      end
    end
  end

  assign bus.q     = q_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench for two counter configurations: 2-digit /4 wrap 59, 4-digit /1 wrap 9999.
module tb_bcd_counter_multi;
  logic clk = 1'b0;
  logic clr;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bcd_counter_multi_if #(.DIGITS(2)) a_if ();
  bcd_counter_multi_if #(.DIGITS(4)) b_if ();

  bcd_counter_multi #(.DIGITS(2), .DIV(4), .TOP(8'h59)) u_a (
    .clk (clk),
    .clr (clr),
    .bus (a_if.slave)
  );

  bcd_counter_multi #(.DIGITS(4), .DIV(1), .TOP(16'h9999)) u_b (
    .clk (clk),
    .clr (clr),
    .bus (b_if.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  initial begin
    clr = 1'b1;
    a_if.en = 1'b0; a_if.load = 1'b0; a_if.up = 1'b1; a_if.in = '0;
    b_if.en = 1'b0; b_if.load = 1'b0; b_if.up = 1'b1; b_if.in = '0;
    cyc(); cyc();
    check("rst_a_q", 16'(a_if.q), 16'h0);
    check("rst_a_tick", 16'(a_if.tick), 16'h0);
    check("rst_a_carry", 16'(a_if.carry), 16'h0);
    check("rst_b_q", b_if.q, 16'h0);

    // Count up through a full 60-tick cycle.
    clr = 1'b0; a_if.en = 1'b1; a_if.up = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      repeat (3) begin
        cyc();
        check("up_idle_tick", 16'(a_if.tick), 16'h0);
        check("up_idle_carry", 16'(a_if.carry), 16'h0);
      end
      cyc();
      check("up_q", 16'(a_if.q), 16'(bcd2(t % 60)));
      check("up_tick", 16'(a_if.tick), 16'h1);
      check("up_carry", 16'(a_if.carry), (t == 60) ? 16'h1 : 16'h0);
    end
    cyc();
    check("up_carry_single", 16'(a_if.carry), 16'h0);

    // Load then count down to a borrow wrap.
    a_if.load = 1'b1; a_if.in = 8'h37;
    cyc();
    a_if.load = 1'b0; a_if.up = 1'b0;
    check("ld37_q", 16'(a_if.q), 16'h37);
    check("ld37_carry", 16'(a_if.carry), 16'h0);
    repeat (3) cyc();
    check("ld37_hold", 16'(a_if.q), 16'h37);
    cyc();
    check("dn_first", 16'(a_if.q), 16'h36);
    repeat (36 * 4) cyc();
    check("dn_zero", 16'(a_if.q), 16'h00);
    check("dn_zero_carry", 16'(a_if.carry), 16'h0);
    repeat (4) cyc();
    check("dn_wrap_q", 16'(a_if.q), 16'h59);
    check("dn_wrap_carry", 16'(a_if.carry), 16'h1);
    cyc();
    check("dn_wrap_carry_off", 16'(a_if.carry), 16'h0);

    // Sanitised load and load above TOP.
    a_if.load = 1'b1; a_if.in = 8'hA5;
    cyc();
    check("ld_sanitise", 16'(a_if.q), 16'h05);
    a_if.in = 8'h75; a_if.up = 1'b1;
    cyc();
    a_if.load = 1'b0;
    check("ld_above_top", 16'(a_if.q), 16'h75);
    repeat (4) cyc();
    check("above_top_wrap_q", 16'(a_if.q), 16'h00);
    check("above_top_wrap_carry", 16'(a_if.carry), 16'h1);

    // Enable freeze mid-prescale.
    a_if.load = 1'b1; a_if.in = 8'h00;
    cyc();
    a_if.load = 1'b0;
    repeat (2) cyc();
    a_if.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("frz_q", 16'(a_if.q), 16'h00);
      check("frz_tick", 16'(a_if.tick), 16'h0);
    end
    a_if.en = 1'b1;
    cyc();
    check("resume_q0", 16'(a_if.q), 16'h00);
    check("resume_tick0", 16'(a_if.tick), 16'h0);
    cyc();
    check("resume_q1", 16'(a_if.q), 16'h01);
    check("resume_tick1", 16'(a_if.tick), 16'h1);

    // clr with load on a step cycle.
    repeat (3) cyc();
    clr = 1'b1; a_if.load = 1'b1; a_if.in = 8'h42;
    cyc();
    check("clr_pri_q", 16'(a_if.q), 16'h00);
    check("clr_pri_carry", 16'(a_if.carry), 16'h0);
    check("clr_pri_tick", 16'(a_if.tick), 16'h0);
    clr = 1'b0; a_if.load = 1'b0;
    repeat (3) cyc();
    // Load on a step cycle wins over the increment.
    a_if.load = 1'b1; a_if.in = 8'h22;
    cyc();
    a_if.load = 1'b0;
    check("ld_step_q", 16'(a_if.q), 16'h22);
    check("ld_step_carry", 16'(a_if.carry), 16'h0);
    repeat (3) cyc();
    check("ld_step_hold", 16'(a_if.q), 16'h22);
    cyc();
    check("ld_step_next", 16'(a_if.q), 16'h23);
    a_if.en = 1'b0;

    // Four digits, step every cycle.
    b_if.en = 1'b1; b_if.up = 1'b1; b_if.load = 1'b1; b_if.in = 16'h0999;
    cyc();
    check("b_ld0999", b_if.q, 16'h0999);
    b_if.load = 1'b0;
    cyc();
    check("b_ripple", b_if.q, 16'h1000);
    check("b_tick", 16'(b_if.tick), 16'h1);
    check("b_ripple_carry", 16'(b_if.carry), 16'h0);
    b_if.load = 1'b1; b_if.in = 16'h9A9F;
    cyc();
    check("b_sanitise", b_if.q, 16'h9090);
    b_if.in = 16'h9999;
    cyc();
    check("b_ld9999", b_if.q, 16'h9999);
    check("b_ld_carry", 16'(b_if.carry), 16'h0);
    b_if.load = 1'b0;
    cyc();
    check("b_up_wrap_q", b_if.q, 16'h0000);
    check("b_up_wrap_carry", 16'(b_if.carry), 16'h1);
    b_if.up = 1'b0;
    cyc();
    check("b_dn_wrap_q", b_if.q, 16'h9999);
    check("b_dn_wrap_carry", 16'(b_if.carry), 16'h1);
    cyc();
    check("b_dn_q", b_if.q, 16'h9998);
    check("b_dn_carry", 16'(b_if.carry), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-digit BCD up/down counter with an internal clock-enable prescaler.
- Successor to the single-digit decimal counter:
  - all logic runs on the single system clock;
  - a one-cycle tick replaces any derived clock;
  - adds digit count, a programmable wrap value, count direction, enable and a carry/borrow pulse.
- Drives seven-segment or timer display paths, e.g. seconds/minutes stages chained through carry.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- DIV, 50000000, clk cycles per count tick (>=1); DIV=1 ticks every enabled cycle.
- TOP, 8'h99, wrap value in BCD, width 4*DIGITS; every digit of TOP must be <=9.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- en  in  1  count enable; gates the prescaler and counting.
- load  in  1  synchronous parallel load of in.
- up  in  1  direction: 1 = up, 0 = down; sampled on the tick cycle.
- in  in  4*DIGITS  BCD load value, digit 0 in bits [3:0].
- q  out  4*DIGITS  registered BCD count.
- tick  out  1  registered one-cycle pulse, the cycle after the prescaler reaches DIV-1.
- carry  out  1  registered one-cycle pulse, coincident with the q update on wrap (up TOP->0, down 0->TOP).

Behaviour:
- Reset:
  - clr=1 at a clk edge sets q=0, prescaler=0, tick=0, carry=0.
  - clr has priority over every other input.
  - Reset mid-count discards any pending tick.
- Prescaler:
  - Counter psc of width clog2(DIV), min 1 bit.
  - When en=1: psc increments; at DIV-1 it returns to 0 and an internal step is raised for that cycle.
  - When en=0: psc holds and no step occurs.
  - tick register is the step delayed by one cycle; q updates on the same edge tick goes high.
- Priority each edge: clr > load > step > hold.
- Load:
  - load=1 (clr=0) writes in to q immediately, without waiting for a tick.
  - psc is cleared, so the next step is DIV enabled cycles later.
  - carry=0 on load.
  - Any input digit >9 is stored as 0 (sanitised per digit).
  - A loaded value above TOP is kept. The next up-step from a value >=TOP wraps to 0 with carry; a down-step decrements normally.
- Step, up=1:
  - If q==TOP (or q>TOP), q<=0 and carry<=1.
  - Otherwise BCD increment: digit 0 +1; a digit reaching 10 becomes 0 and carries into the next digit. The whole ripple resolves in one cycle.
- Step, up=0:
  - If q==0, q<=TOP and carry<=1.
  - Otherwise BCD decrement: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
- carry is high for exactly one clk cycle per wrap and is 0 on every other cycle.
- q never holds a non-BCD digit.
- up changing between steps has no effect until the next step cycle.
- en falling on the step cycle: that step still executes. The step condition is psc==DIV-1 && en, evaluated in the same cycle.
- No combinational path from inputs to outputs; all outputs are registered.
- Synthesisable and latch-free. No derived clocks: do not use a generated clock as an edge source.

Test Plan:
1. DIGITS=2, DIV=4, TOP=8'h59, up=1, en=1 after clr -> tick every 4th cycle; q steps 00,01,...,09,10 (BCD rollover). After 60 ticks q=00 and carry pulses once, coincident with the 59->00 update.
2. Same config, load=1 with in=8'h37, then up=0 -> q=37 the cycle after load; first step exactly 4 enabled cycles later gives 36. Continue to 00; the next step gives q=59 with carry=1.
3. Load in=8'hA5 -> q=8'h05 (digit 1 sanitised). Load in=8'h75 (>TOP) with up=1 -> next step q=00, carry=1.
4. en toggling: en=0 for 10 cycles mid-prescale -> psc and q frozen, no tick. Resume -> the remaining prescale cycles complete, then a single step.
5. Simultaneous events:
   - clr=1 together with load=1 and step -> q=00, carry=0.
   - load=1 on a step cycle -> q=in, no increment, carry=0.
6. DIGITS=4, DIV=1, TOP=16'h9999, up=1, load 16'h0999 -> next cycle q=1000. Load 16'h9999 -> next q=0000, carry=1; with up=0 from 0000 -> q=9999, carry=1.
